board_input: RTL and testbench

BOARD_INPUT -- requirements
Module: board_input

---
 rtl/board_io_pkg.sv | 18 +
 rtl/debounce_bit.sv | 91 +++++++++
 rtl/board_input.sv | 100 ++++++++++
 tb/tb_board_input.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and types for the board input block: read map, bit counts
// and the per-bit debouncer state.
package board_io_pkg;

    localparam int NUM_SW  = 10;
    localparam int NUM_KEY = 4;

    localparam logic [1:0] ADDR_SW  = 2'd0;
    localparam logic [1:0] ADDR_KEY = 2'd1;
    localparam logic [1:0] ADDR_EVT = 2'd2;
    localparam logic [1:0] ADDR_ID  = 2'd3;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchronizer and debouncer: a new level is accepted only after
// DEB_CYCLES consecutive synchronized samples that differ from the current one.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int   DEB_CYCLES = 50000,
    parameter logic INVERT     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic        w_sample;
    deb_state_e  r_state;
    deb_state_e  w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic        r_stable;
    logic        w_stable_next;

    // Two-flop synchronizer on the raw input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = INVERT ? ~r_sync2 : r_sync2;

    // Debouncer state, counter and accepted level
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_STABLE;
            r_cnt    <= 16'd0;
            r_stable <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_stable <= w_stable_next;
        end
    end

    // Next state: the terminal count ends CHANGING before the counter can wrap
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_stable_next = r_stable;
        case (r_state)
            ST_STABLE: begin
                if (w_sample != r_stable) begin
                    w_state_next = ST_CHANGING;
                    w_cnt_next   = 16'd1;
                end else begin
                    w_cnt_next   = 16'd0;
                end
            end
            ST_CHANGING: begin
                if (w_sample == r_stable) begin
                    w_state_next = ST_STABLE;
                    w_cnt_next   = 16'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next  = ST_STABLE;
                    w_cnt_next    = 16'd0;
                    w_stable_next = w_sample;
                end else begin
                    w_cnt_next   = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
                w_cnt_next   = 16'd0;
            end
        endcase
    end

    // Output is the registered accepted level
    always_comb begin
        o_level = r_stable;
    end

endmodule

// File: rtl/board_input.sv
// Debounced switch/key front end with press-edge detection, sticky key event
// flags and a small one-cycle-latency read port.
module board_input
    import board_io_pkg::*;
#(
    parameter int          DEB_CYCLES = 50000,
    parameter logic [31:0] ID_VALUE   = 32'h0B0A_2D01
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_SW-1:0]   SW,
    input  logic [NUM_KEY-1:0]  KEY,
    output logic [NUM_SW-1:0]   sw_level,
    output logic [NUM_KEY-1:0]  key_level,
    output logic [NUM_KEY-1:0]  key_press,
    input  logic                rd_en,
    input  logic [1:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic                rd_valid
);

    localparam int NUM_BITS = NUM_SW + NUM_KEY;

    logic [NUM_BITS-1:0] w_raw;
    logic [NUM_BITS-1:0] w_level;
    logic [NUM_KEY-1:0]  r_key_prev;
    logic [NUM_KEY-1:0]  r_key_press;
    logic [NUM_KEY-1:0]  r_events;
    logic [NUM_KEY-1:0]  w_evt_clr;
    logic [31:0]         w_rd_mux;
    logic [31:0]         r_rd_data;
    logic                r_rd_valid;

    assign w_raw = {KEY, SW};

    // Keys occupy the upper bits and are inverted after synchronization
    genvar g;
    generate
        for (g = 0; g < NUM_BITS; g++) begin : g_deb
            debounce_bit #(
                .DEB_CYCLES (DEB_CYCLES),
                .INVERT     ((g >= NUM_SW) ? 1'b1 : 1'b0)
            ) u_deb (
                .i_clk   (CLOCK_50),
                .i_rst_n (reset),
                .i_raw   (w_raw[g]),
                .o_level (w_level[g])
            );
        end
    endgenerate

    assign sw_level  = w_level[NUM_SW-1:0];
    assign key_level = w_level[NUM_BITS-1:NUM_SW];
    assign key_press = r_key_press;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;

    // Press pulse the cycle after a debounced key rises
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_key_prev  <= {NUM_KEY{1'b0}};
            r_key_press <= {NUM_KEY{1'b0}};
        end else begin
            r_key_prev  <= key_level;
            r_key_press <= key_level & ~r_key_prev;
        end
    end

    // Read mux; reading the event register clears exactly the bits returned
    always_comb begin
        w_rd_mux  = 32'd0;
        w_evt_clr = {NUM_KEY{1'b0}};
        case (rd_addr)
            ADDR_SW:  w_rd_mux = {{(32-NUM_SW){1'b0}}, sw_level};
            ADDR_KEY: w_rd_mux = {{(32-NUM_KEY){1'b0}}, key_level};
            ADDR_EVT: w_rd_mux = {{(32-NUM_KEY){1'b0}}, r_events};
            ADDR_ID:  w_rd_mux = ID_VALUE;
            default:  w_rd_mux = 32'd0;
        endcase
        if (rd_en && (rd_addr == ADDR_EVT)) begin
            w_evt_clr = r_events;
        end else begin
            w_evt_clr = {NUM_KEY{1'b0}};
        end
    end

    // Sticky events (set beats clear) and registered read response
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_events   <= {NUM_KEY{1'b0}};
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_events   <= (r_events & ~w_evt_clr) | r_key_press;
            r_rd_valid <= rd_en;
            r_rd_data  <= rd_en ? w_rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_board_input.sv
// Randomized scoreboard bench for board_input with a window-based reference
// model of the debounced levels, press pulses, sticky events and read port.
module tb_board_input;

    localparam int          DEB = 4;
    localparam logic [31:0] ID  = 32'h0B0A_2D01;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [9:0]  SW;
    logic [3:0]  KEY;
    logic [9:0]  sw_level;
    logic [3:0]  key_level;
    logic [3:0]  key_press;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int rb;

    // Reference model state
    logic [13:0] dly[$];
    logic [13:0] win[$];
    logic [31:0] exp_q[$];
    logic [13:0] m_level;
    logic [3:0]  m_press;
    logic [3:0]  m_prev_key;
    logic [3:0]  m_evt;

    board_input #(.DEB_CYCLES(DEB), .ID_VALUE(ID)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .SW        (SW),
        .KEY       (KEY),
        .sw_level  (sw_level),
        .key_level (key_level),
        .key_press (key_press),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a level flips once the last DEB post-reset samples all disagree with it;
    // samples reach the debouncer two clocks after the raw pins (flops reset to raw 0).
    always @(posedge CLOCK_50) begin
        logic [31:0] d;
        logic [3:0]  clr;
        logic [13:0] s;
        logic [13:0] nl;
        logic        all_diff;
        if (!reset) begin
            dly.delete();
            dly.push_back(14'h3C00);
            dly.push_back(14'h3C00);
            win.delete();
            exp_q.delete();
            m_level    = 14'd0;
            m_press    = 4'd0;
            m_prev_key = 4'd0;
            m_evt      = 4'd0;
        end else begin
            clr = 4'd0;
            if (rd_en) begin
                case (rd_addr)
                    2'd0:    d = {22'd0, m_level[9:0]};
                    2'd1:    d = {28'd0, m_level[13:10]};
                    2'd2:    d = {28'd0, m_evt};
                    default: d = ID;
                endcase
                exp_q.push_back(d);
                if (rd_addr == 2'd2) clr = m_evt;
            end
            m_evt = (m_evt & ~clr) | m_press;
            dly.push_back({~KEY, SW});
            s = dly.pop_front();
            win.push_back(s);
            if (win.size() > DEB) void'(win.pop_front());
            nl = m_level;
            if (win.size() == DEB) begin
                for (int i = 0; i < 14; i++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < DEB; j++) begin
                        if (win[j][i] == m_level[i]) all_diff = 1'b0;
                    end
                    if (all_diff) nl[i] = ~m_level[i];
                end
            end
            m_press    = m_level[13:10] & ~m_prev_key;
            m_prev_key = m_level[13:10];
            m_level    = nl;
        end
    end

    // Monitor: compare outputs just after each edge; reads are popped from the scoreboard
    always @(posedge CLOCK_50) begin
        logic [31:0] e;
        #1;
        if (!reset) begin
            check("reset_outputs", 32'({sw_level, key_level, key_press, rd_valid}), 32'd0);
            check("reset_rd_data", rd_data, 32'd0);
        end else begin
            check("sw_level", 32'(sw_level), 32'(m_level[9:0]));
            check("key_level", 32'(key_level), 32'(m_level[13:10]));
            check("key_press", 32'(key_press), 32'(m_press));
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rd_valid_missing", 32'(rd_valid), 32'd1);
                end
                check("rd_data_idle", rd_data, 32'd0);
            end
        end
    end

    task automatic do_read(input logic [1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge CLOCK_50);
        rd_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    initial begin
        reset   = 1'b0;
        SW      = 10'h000;
        KEY     = 4'hF;
        rd_en   = 1'b0;
        rd_addr = 2'd0;
        idle(3);
        // all switches held through reset release
        SW = 10'h3FF;
        idle(1);
        reset = 1'b1;
        idle(10);
        // bouncing KEY[2] that finally settles pressed
        KEY[2] = 1'b0; idle(2);
        KEY[2] = 1'b1; idle(2);
        KEY[2] = 1'b0; idle(12);
        // press KEY[0] then read-clear events twice
        KEY[0] = 1'b0; idle(12);
        do_read(2'd2);
        do_read(2'd2);
        idle(2);
        // read-clear coinciding with the KEY[1] press pulse
        KEY[1] = 1'b0;
        idle(7);
        do_read(2'd2);
        do_read(2'd2);
        idle(2);
        // back-to-back reads across the whole map
        for (int a = 0; a < 4; a++) begin
            rd_en   = 1'b1;
            rd_addr = 2'(a);
        end
        rd_en = 1'b1; rd_addr = 2'd0; idle(1);
        rd_addr = 2'd1; idle(1);
        rd_addr = 2'd2; idle(1);
        rd_addr = 2'd3; idle(1);
        rd_en = 1'b0;
        idle(3);
        // reset in the middle of a count discards it
        KEY = 4'hF;
        SW  = 10'h155;
        idle(4);
        reset = 1'b0; idle(2);
        reset = 1'b1; idle(12);
        // randomized phase: sparse switch changes, bouncy keys, random reads
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15, 0) == 0) begin
                rb = $urandom_range(9, 0);
                SW[rb] = ~SW[rb];
            end
            if ($urandom_range(7, 0) == 0) begin
                rb = $urandom_range(3, 0);
                KEY[rb] = ~KEY[rb];
            end
            rd_en   = ($urandom_range(2, 0) == 0);
            rd_addr = 2'($urandom_range(3, 0));
            if ($urandom_range(599, 0) == 0) begin
                rd_en = 1'b0;
                idle(1);
                reset = 1'b0; idle(2);
                reset = 1'b1;
            end
            idle(1);
        end
        rd_en = 1'b0;
        idle(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
